// File: rtl/spi_rom_arbiter.sv
// Two-requester SPI-ROM read arbiter: one mode-0 read (0x03) burst at a time, 1..256 bytes.
// Define SPI_ROM_ARB_RR_EN for round-robin grants; otherwise requester 0 has fixed priority.
module spi_rom_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  input  logic [7:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  input  logic [7:0]  req1_len,
  output logic        req1_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_id,
  output logic        rd_last,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_e;

  state_e      state_q, state_d;
  logic        phase_q;
  logic [4:0]  bit_q;
  logic [31:0] tx_q;
  logic [6:0]  rx_q;
  logic [8:0]  rem_q;
  logic        id_q;
  logic        gap_q;
  logic        rd_valid_q, rd_last_q, rd_id_q;
  logic [7:0]  rd_data_q;

  logic        gnt0, gnt1, accept, shifting, bit_end, field_end;
  logic [23:0] sel_addr;
  logic [7:0]  sel_len;

`ifdef SPI_ROM_ARB_RR_EN
  // pref_q high means requester 1 wins the next simultaneous request
  logic pref_q;
  always_ff @(posedge clk) begin
    if (rst)         pref_q <= 1'b0;
    else if (accept) pref_q <= req0_ready;
  end
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || !pref_q);
    gnt1 = req1_valid && (!req0_valid || pref_q);
  end
`else
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid && !req0_valid;
  end
`endif

  assign accept    = req0_ready || req1_ready;
  assign sel_addr  = req1_ready ? req1_addr : req0_addr;
  assign sel_len   = req1_ready ? req1_len  : req0_len;
  assign shifting  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign bit_end   = shifting && phase_q;
  assign field_end = bit_end && ((state_q == ADDR) ? (bit_q == 5'd23) : (bit_q == 5'd7));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                       state_d = CMD;
      CMD:     if (field_end)                    state_d = ADDR;
      ADDR:    if (field_end)                    state_d = DATA;
      DATA:    if (field_end && rem_q == 9'd1)   state_d = GAP;
      GAP:     if (gap_q)                        state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_csb    = !shifting;
    spi_sclk   = shifting && phase_q;
    spi_mosi   = ((state_q == CMD) || (state_q == ADDR)) && tx_q[31];
    busy       = (state_q != IDLE);
    req0_ready = (state_q == IDLE) && !rst && gnt0;
    req1_ready = (state_q == IDLE) && !rst && gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rem_q      <= '0;
      id_q       <= 1'b0;
      gap_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          phase_q <= 1'b0;
          bit_q   <= '0;
          gap_q   <= 1'b0;
          if (accept) begin
            tx_q  <= {8'h03, sel_addr};
            rem_q <= (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
            id_q  <= req1_ready;
          end
        end
        CMD, ADDR, DATA: begin
          phase_q <= ~phase_q;
          // end of phase B: advance MOSI, sample MISO
          if (phase_q) begin
            bit_q <= field_end ? '0 : bit_q + 5'd1;
            tx_q  <= {tx_q[30:0], 1'b0};
            rx_q  <= {rx_q[5:0], spi_miso};
            if (state_q == DATA && bit_q == 5'd7) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= {rx_q, spi_miso};
              rd_id_q    <= id_q;
              rd_last_q  <= (rem_q == 9'd1);
              rem_q      <= rem_q - 9'd1;
            end
          end
        end
        GAP:     gap_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Directed bench for spi_rom_arbiter with a behavioural SPI ROM (byte k of a burst = pat + k).
module tb_spi_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic [7:0]  req0_len, req1_len;
  logic        req0_ready, req1_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_id, rd_last;
  logic        spi_csb, spi_sclk, spi_mosi, spi_miso;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last),
    .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI ROM model
  logic [7:0]  pat = 8'hA5;
  int          nbits = 0;
  logic [31:0] mosi_word = '0;
  int          d;
  logic [7:0]  bb;

  always @(negedge spi_csb) begin nbits = 0; mosi_word = '0; end
  always @(posedge spi_sclk) if (!spi_csb && nbits < 32) mosi_word = {mosi_word[30:0], spi_mosi};
  always @(negedge spi_sclk) nbits = nbits + 1;
  always_comb begin
    d = 0;
    bb = '0;
    spi_miso = 1'b0;
    if (nbits >= 32) begin
      d = nbits - 32;
      bb = pat + 8'(d / 8);
      spi_miso = bb[3'(7 - (d % 8))];
    end
  end

  // Output monitor
  typedef struct { int c; logic [7:0] data; logic id; logic last; } rd_t;
  rd_t rd_q[$];
  int  csb_fall[$], csb_rise[$];
  int  acc_cyc[$];
  logic acc_id[$];
  logic csb_prev = 1'b1;
  int  both_ready = 0;
  int  mosi_bad = 0;

  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back('{cyc, rd_data, rd_id, rd_last});
    if (!spi_csb && csb_prev) csb_fall.push_back(cyc);
    if (spi_csb && !csb_prev) csb_rise.push_back(cyc);
    csb_prev = spi_csb;
    if (req0_ready && req1_ready) both_ready++;
    if (spi_csb && spi_mosi) mosi_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete(); csb_fall.delete(); csb_rise.delete(); acc_cyc.delete(); acc_id.delete();
  endtask

  task automatic wait_acc(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(req1_valid && req1_ready);
        break;
      end
    end
    if (i == budget) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == budget) check("idle_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic id, input logic [23:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_addr = a; req1_len = l; end
    else    begin req0_valid = 1'b1; req0_addr = a; req0_len = l; end
    wait_acc(200);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int t, t2, nlast;
  logic [2:0] exp_g;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_csb", spi_csb, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;

    // single-byte read
    clear_log();
    pat = 8'hA5;
    send(1'b0, 24'h012345, 8'd1);
    wait_idle(300);
    t = acc_cyc[0];
    check("t1_id", acc_id[0], 0);
    check("t1_csb_fall", csb_fall[0] - t, 1);
    check("t1_mosi", mosi_word, 32'h03012345);
    check("t1_nrd", rd_q.size(), 1);
    check("t1_rd_cyc", rd_q[0].c - t, 81);
    check("t1_rd_data", rd_q[0].data, 8'hA5);
    check("t1_rd_id", rd_q[0].id, 0);
    check("t1_rd_last", rd_q[0].last, 1);
    check("t1_csb_rise", csb_rise[0] - t, 81);

    // len 0 = 256 bytes from requester 1
    clear_log();
    pat = 8'h10;
    send(1'b1, 24'hABCDEF, 8'd0);
    wait_idle(5000);
    t = acc_cyc[0];
    nlast = 0;
    foreach (rd_q[i]) if (rd_q[i].last) nlast++;
    check("t2_id", acc_id[0], 1);
    check("t2_nrd", rd_q.size(), 256);
    check("t2_nlast", nlast, 1);
    check("t2_last_at_end", rd_q[255].last, 1);
    check("t2_rd_id", rd_q[255].id, 1);
    check("t2_data0", rd_q[0].data, 8'h10);
    check("t2_data255", rd_q[255].data, 8'h0F);
    check("t2_rd_cyc255", rd_q[255].c - t, 81 + 16 * 255);
    check("t2_csb_low", csb_rise[0] - csb_fall[0], 4160);

    // simultaneous requests, three grants
    clear_log();
    pat = 8'h30;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 24'h000010; req0_len = 8'd1;
    req1_valid = 1'b1; req1_addr = 24'h000020; req1_len = 8'd1;
    repeat (3) wait_acc(300);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(300);
`ifdef SPI_ROM_ARB_RR_EN
    exp_g = 3'b010;
`else
    exp_g = 3'b000;
`endif
    check("t3_ngrant", acc_id.size(), 3);
    check("t3_grant0", acc_id[0], exp_g[2]);
    check("t3_grant1", acc_id[1], exp_g[1]);
    check("t3_grant2", acc_id[2], exp_g[0]);
    check("t3_rd_id1", rd_q[1].id, exp_g[1]);
    check("t3_one_ready", both_ready, 0);

    // reset in the middle of a len-4 burst
    clear_log();
    pat = 8'h77;
    send(1'b0, 24'h000100, 8'd4);
    t = acc_cyc[0];
    for (int i = 0; i < 200; i++) begin
      if (cyc == t + 70) break;
      @(posedge clk); #1;
    end
    check("t4_at_t70", cyc - t, 70);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_csb", spi_csb, 1);
    check("t4_sclk", spi_sclk, 0);
    check("t4_busy", busy, 0);
    check("t4_rd_valid", rd_valid, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("t4_nrd", rd_q.size(), 0);
    check("t4_nfall", csb_fall.size(), 1);

    // back-to-back requests from requester 0
    clear_log();
    pat = 8'h50;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 24'h000200; req0_len = 8'd2;
    wait_acc(200);
    @(posedge clk); #1;
    req0_addr = 24'h000300;
    wait_acc(300);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle(300);
    t  = acc_cyc[0];
    t2 = acc_cyc[1];
    check("t5_gap_to_accept", t2 - csb_rise[0], 2);
    check("t5_csb_high", csb_fall[1] - csb_rise[0], 3);
    check("t5_nrd", rd_q.size(), 4);
    check("t5_last0", rd_q[0].last, 0);
    check("t5_last1", rd_q[1].last, 1);
    check("t5_data1", rd_q[1].data, 8'h51);
    check("t5_rd2_cyc", rd_q[2].c - t2, 81);
    check("t5_last3", rd_q[3].last, 1);
    check("mosi_idle_zero", mosi_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1);
  end

endmodule

// File: doc/spi_rom_arbiter.md
SPI_ROM_ARBITER -- requirements
Module: spi_rom_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req0_valid in 1, req0_addr in 24, req0_len in 8, req0_ready out 1; requester 0 (video line fetch).
REQ-004 SHALL have: req1_valid in 1, req1_addr in 24, req1_len in 8, req1_ready out 1; requester 1 (auxiliary/debug fetch).
REQ-005 SHALL have: rd_data out 8 (byte read), rd_valid out 1 (1-cycle pulse), rd_id out 1 (owning requester), rd_last out 1 (final byte of burst).
REQ-006 SHALL have: spi_csb out 1, spi_sclk out 1, spi_mosi out 1, spi_miso in 1; SPI mode 0 to external ROM.
REQ-007 SHALL have: busy out 1, high in every state except IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> CMD -> ADDR -> DATA -> GAP -> IDLE.
REQ-009 In IDLE SHALL assert exactly one reqN_ready, combinationally, only for the granted requester with reqN_valid high; acceptance = valid & ready in the same cycle (cycle T).
REQ-010 SHALL latch addr and len at T; requester inputs are ignored thereafter until the next IDLE.
REQ-011 len SHALL be 8-bit unsigned; 0 SHALL mean 256 bytes; byte counter 9 bits.
REQ-012 Each SPI bit SHALL take 2 clk cycles: phase A spi_sclk=0 with spi_mosi updated, phase B spi_sclk=1; spi_miso sampled on the clk edge ending phase B.
REQ-013 spi_csb SHALL go low at T+1; CMD sends 0x03 MSB first over T+1..T+16; ADDR sends the 24-bit address MSB first over T+17..T+64.
REQ-014 DATA byte k (0-based) SHALL occupy T+65+16k..T+80+16k, MSB first; rd_valid SHALL pulse at T+81+16k with rd_data, rd_id held valid that cycle.
REQ-015 rd_last SHALL be high only with the rd_valid of byte len-1 (byte 255 when len=0).
REQ-016 spi_csb SHALL return high at T+65+16*len_eff; GAP SHALL hold spi_csb high, spi_sclk low for 2 cycles before IDLE.
REQ-017 SHALL apply no back-pressure on read data; the consumer accepts every rd_valid pulse.
REQ-018 spi_mosi SHALL be 0 during DATA, GAP, IDLE.
REQ-019 Request arriving while busy SHALL wait with valid high; it SHALL NOT be dropped or reordered against itself.

Reset
REQ-020 With rst high at a clk edge: FSM -> IDLE, spi_csb=1, spi_sclk=0, spi_mosi=0, rd_valid=0, rd_last=0, rd_data=0, rd_id=0, busy=0, arbitration pointer -> requester 0.
REQ-021 rst mid-transfer SHALL abort; no rd_valid follows; next acceptance no earlier than the first cycle after rst deasserts.
REQ-022 reqN_ready SHALL be 0 while rst is high.

Configuration
REQ-023 Macro SPI_ROM_ARB_RR_EN defined: round-robin grant; after serving requester N, the other requester wins a simultaneous request.
REQ-024 Macro SPI_ROM_ARB_RR_EN undefined: fixed priority; requester 0 always wins simultaneous requests.

Verification
REQ-025 req0 addr 0x012345 len 1, miso model returns 0xA5 -> mosi shows 0x03,0x01,0x23,0x45; rd_valid at T+81, rd_data 0xA5, rd_id 0, rd_last 1; csb high at T+81.
REQ-026 req1 len 0 -> exactly 256 rd_valid pulses, rd_last only on the 256th, csb low for 64+4096 cycles.
REQ-027 req0 and req1 both valid in IDLE, repeated 3 times -> fixed: grants 0,0,0; with SPI_ROM_ARB_RR_EN: 0,1,0.
REQ-028 rst asserted at T+70 of a len-4 burst -> next edge csb=1, sclk=0, no further rd_valid, busy=0.
REQ-029 Back-to-back req0 len 2 pending -> second acceptance 2 GAP cycles after first csb rise; csb high for at least 2 cycles between bursts.
